// File: rtl/cacheline_bus_adapter.sv
// Cache-side master: one 256-bit line read/write serialised as address beat + 8 data beats.
// Latency: min 10 cycles (read) / 11 cycles (write) request->dfp_resp; backpressure via resp_m_to_c, watchdog aborts stalls.
module cacheline_bus_adapter #(
    parameter int LINE_WIDTH     = 256,
    parameter int BUS_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,
    output logic                  error,
    output logic                  read_en_c_to_m,
    output logic                  write_en_c_to_m,
    output logic                  address_on_c_to_m,
    output logic                  data_on_c_to_m,
    output logic [BUS_WIDTH-1:0]  address_data_bus_c_to_m,
    input  logic [BUS_WIDTH-1:0]  address_data_bus_m_to_c,
    input  logic                  resp_m_to_c
);

    localparam int BEATS  = LINE_WIDTH / BUS_WIDTH;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
    localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_WDONE,
        S_RDATA,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    is_rd_q, is_rd_d;
    logic                    error_q, error_d;
    logic                    active;
    logic                    timeout;
    logic                    addr_offset_unused;

    // Line offset bits are dropped: every transfer is line aligned.
    assign addr_offset_unused = ^dfp_addr[OFF_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            wd_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            is_rd_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wd_q    <= wd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            is_rd_q <= is_rd_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wd_d    = wd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        is_rd_d = is_rd_q;
        error_d = error_q;

        active  = (state_q == S_ADDR) || (state_q == S_WDATA) ||
                  (state_q == S_WDONE) || (state_q == S_RDATA);
        timeout = (TIMEOUT_CYCLES != 0) && active && !resp_m_to_c && (wd_q == WD_LAST);

        if (active) begin
            wd_d = resp_m_to_c ? '0 : wd_q + WD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                wd_d = '0;
                if (dfp_read || dfp_write) begin
                    addr_d  = {dfp_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    wdata_d = dfp_wdata;
                    is_rd_d = dfp_read;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (resp_m_to_c) begin
                    beat_d  = '0;
                    state_d = is_rd_q ? S_RDATA : S_WDATA;
                end
            end
            S_WDATA: begin
                if (resp_m_to_c) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_LAST) begin
                        beat_d  = '0;
                        state_d = S_WDONE;
                    end
                end
            end
            S_WDONE: begin
                if (resp_m_to_c) begin
                    state_d = S_DONE;
                end
            end
            S_RDATA: begin
                if (resp_m_to_c) begin
                    rdata_d[BUS_WIDTH*beat_q +: BUS_WIDTH] = address_data_bus_m_to_c;
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_LAST) begin
                        beat_d  = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A stalled handshake completes the request with the sticky error set.
        if (timeout) begin
            error_d = 1'b1;
            beat_d  = '0;
            wd_d    = '0;
            state_d = S_DONE;
        end
    end

    always_comb begin
        read_en_c_to_m          = is_rd_q && ((state_q == S_ADDR) || (state_q == S_RDATA));
        write_en_c_to_m         = !is_rd_q && ((state_q == S_ADDR) || (state_q == S_WDATA) ||
                                               (state_q == S_WDONE));
        address_on_c_to_m       = (state_q == S_ADDR);
        data_on_c_to_m          = (state_q == S_WDATA);
        address_data_bus_c_to_m = '0;
        if (state_q == S_ADDR) begin
            address_data_bus_c_to_m = BUS_WIDTH'(addr_q);
        end else if (state_q == S_WDATA) begin
            address_data_bus_c_to_m = wdata_q[BUS_WIDTH*beat_q +: BUS_WIDTH];
        end
    end

    assign dfp_resp  = (state_q == S_DONE);
    assign dfp_rdata = rdata_q;
    assign error     = error_q;

endmodule
